// File: rtl/iq_nco_lookup_scheduler_if.sv
// Sample-strobe, FCW, lookup and I/Q output bundle for iq_nco_lookup_scheduler.
// slave = scheduler side; master = timing generator / lookup / mixer side.
interface iq_nco_lookup_scheduler_if #(
  parameter int AW = 32,
  parameter int PW = 12,
  parameter int OW = 16
);
  logic                 i_sample_stb;
  logic                 i_sync;
  logic [AW-1:0]        i_fcw;
  logic                 i_fcw_valid;
  logic                 o_fcw_ready;
  logic [PW-1:0]        o_phase;
  logic                 o_lookup_ce;
  logic signed [OW:0]   i_lookup_val;
  logic signed [OW:0]   o_i;
  logic signed [OW:0]   o_q;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_overrun;

  modport master (
    output i_sample_stb, i_sync, i_fcw, i_fcw_valid, i_lookup_val,
    input  o_fcw_ready, o_phase, o_lookup_ce, o_i, o_q, o_valid, o_busy, o_overrun
  );

  modport slave (
    input  i_sample_stb, i_sync, i_fcw, i_fcw_valid, i_lookup_val,
    output o_fcw_ready, o_phase, o_lookup_ce, o_i, o_q, o_valid, o_busy, o_overrun
  );
endinterface

// File: rtl/iq_nco_lookup_scheduler.sv
// NCO controller time-sharing one quarter-wave lookup between cos (I) and sin (Q).
// Optional phase dithering is enabled by defining PHASE_DITHER_EN.
module iq_nco_lookup_scheduler #(
  parameter int AW  = 32,
  parameter int PW  = 12,
  parameter int OW  = 16,
  parameter int LAT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  iq_nco_lookup_scheduler_if.slave bus
);

  localparam int            CW      = $clog2(LAT + 1) + 1;
  localparam logic [CW-1:0] LAT_CNT = CW'(LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [PW-1:0] QUARTER = {2'b01, {(PW-2){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE_COS = 3'd1,
    ST_ISSUE_SIN = 3'd2,
    ST_WAIT      = 3'd3,
    ST_CAP_SIN   = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [AW-1:0]      acc_r;
  logic [AW-1:0]      fcw_reg_r;
  logic [AW-1:0]      acc_base_s;
  logic [PW-1:0]      ph_s;
  logic [PW-1:0]      ph_r;
  logic [PW-1:0]      phase_r;
  logic [CW-1:0]      cnt_r;
  logic signed [OW:0] cos_r;
  logic signed [OW:0] i_r;
  logic signed [OW:0] q_r;
  logic               ce_r;
  logic               valid_r;
  logic               busy_r;
  logic               overrun_r;
  logic               fcw_ready_r;
  logic               stb_accept_s;
  logic               stb_drop_s;
  logic               fcw_accept_s;
  logic               cos_cap_s;

  assign stb_accept_s = bus.i_sample_stb && (state_r == ST_IDLE);
  assign stb_drop_s   = bus.i_sample_stb && (state_r != ST_IDLE);
  assign fcw_accept_s = bus.i_fcw_valid && fcw_ready_r;
  // cnt_r equals k in cycle Ck, so the cos result lands while still in WAIT
  assign cos_cap_s    = (state_r == ST_WAIT) && (cnt_r == LAT_CNT);
  assign acc_base_s   = bus.i_sync ? {AW{1'b0}} : acc_r;

`ifdef PHASE_DITHER_EN
  localparam int D = ((AW - PW) < 16) ? (AW - PW) : 16;

  logic [15:0]   lfsr_r;
  logic [AW-1:0] dith_sum_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign dith_sum_s = acc_base_s + AW'(lfsr_r[D-1:0]);
  assign ph_s       = dith_sum_s[AW-1 -: PW];

  // Dither sequence advances once per accepted strobe
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      lfsr_r <= 16'hACE1;
    end else if (stb_accept_s) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end
`else
  assign ph_s = acc_base_s[AW-1 -: PW];
`endif

  // Next-state logic for the cos/sin issue and capture sequence
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (stb_accept_s) begin
          state_next_s = ST_ISSUE_COS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE_COS: state_next_s = ST_ISSUE_SIN;
      ST_ISSUE_SIN: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_r == LAT_CNT) begin
          state_next_s = ST_CAP_SIN;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_CAP_SIN:   state_next_s = ST_IDLE;
      default:      state_next_s = ST_IDLE;
    endcase
  end

  // State, cycle counter, accumulator and FCW register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {AW{1'b0}};
      fcw_reg_r <= {AW{1'b0}};
      ph_r      <= {PW{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (stb_accept_s) begin
        cnt_r <= {CW{1'b0}};
        ph_r  <= ph_s;
      end else if (state_r != ST_IDLE) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      // Sync wins over accumulation; a coincident strobe restarts from one step
      if (bus.i_sync) begin
        acc_r <= stb_accept_s ? fcw_reg_r : {AW{1'b0}};
      end else if (stb_accept_s) begin
        acc_r <= acc_r + fcw_reg_r;
      end
      if (fcw_accept_s) begin
        fcw_reg_r <= bus.i_fcw;
      end
    end
  end

  // Registered lookup drive, result capture and status outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      phase_r     <= {PW{1'b0}};
      ce_r        <= 1'b0;
      cos_r       <= '0;
      i_r         <= '0;
      q_r         <= '0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      fcw_ready_r <= 1'b0;
    end else begin
      ce_r        <= (state_next_s == ST_ISSUE_COS) || (state_next_s == ST_ISSUE_SIN) ||
                     (state_next_s == ST_WAIT);
      busy_r      <= (state_next_s != ST_IDLE);
      fcw_ready_r <= (state_next_s == ST_IDLE);
      valid_r     <= (state_r == ST_CAP_SIN);
      overrun_r   <= overrun_r | stb_drop_s;
      if (stb_accept_s) begin
        phase_r <= ph_s + QUARTER;
      end else if (state_r == ST_ISSUE_COS) begin
        phase_r <= ph_r;
      end
      if (cos_cap_s) begin
        cos_r <= bus.i_lookup_val;
      end
      if (state_r == ST_CAP_SIN) begin
        i_r <= cos_r;
        q_r <= bus.i_lookup_val;
      end
    end
  end

  assign bus.o_phase     = phase_r;
  assign bus.o_lookup_ce = ce_r;
  assign bus.o_i         = i_r;
  assign bus.o_q         = q_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_overrun   = overrun_r;
  assign bus.o_fcw_ready = fcw_ready_r;

endmodule
